// File: rtl/adder_pkg.sv
// Shared types and helpers for the bit-serial adder/subtractor.
package adder_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // Bit counter only has to reach WIDTH-1; WIDTH=2 still needs one bit.
    function automatic int unsigned cnt_width(int unsigned width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_adder_n_if.sv
// Operand/result handshake bundle between the requester and the serial adder.
interface serial_adder_n_if #(
    parameter int unsigned WIDTH = 4
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
        output start, a, b, cin, sub,
        input  busy, done, sum, cout, overflow
    );

    modport slave (
        input  start, a, b, cin, sub,
        output busy, done, sum, cout, overflow
    );

endinterface

// File: rtl/full_adder_bit.sv
// Combinational 1-bit full adder; the only arithmetic cell of the serial adder.
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_n.sv
// WIDTH-bit bit-serial adder/subtractor: one bit per clock through a single full-adder cell.
module serial_adder_n
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    serial_adder_n_if.slave  bus
);

    localparam int unsigned CntW = cnt_width(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic fa_s;
    logic fa_cout;

    full_adder_bit u_fa (
        .a    (op_a_q[0]),
        .b    (op_b_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_cout)
    );

    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (bus.start) begin
                    state_d = StRun;
                    op_a_d  = bus.a;
                    op_b_d  = bus.sub ? ~bus.b : bus.b;
                    // Subtract is A + ~B + ~cin, i.e. A - B - cin.
                    carry_d = bus.cin ^ bus.sub;
                    cnt_d   = '0;
                end else if (state_q == StDone) begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                op_a_d  = op_a_q >> 1;
                op_b_d  = op_b_q >> 1;
                res_d   = {fa_s, res_q[WIDTH-1:1]};
                carry_d = fa_cout;
                cnt_d   = cnt_q + CntW'(1);
                if (cnt_q == CntLast) begin
                    sum_d   = res_d;
                    cout_d  = fa_cout;
                    // carry_q is the carry into the MSB on this last bit.
                    ovf_d   = carry_q ^ fa_cout;
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            op_a_q  <= '0;
            op_b_q  <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy     = (state_q == StRun);
    assign bus.done     = (state_q == StDone);
    assign bus.sum      = sum_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder_n.sv
// Directed and random checks of serial_adder_n at WIDTH=4 and WIDTH=8 against an arithmetic model.
module tb_serial_adder_n;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    serial_adder_n_if #(.WIDTH(4)) if4 ();
    serial_adder_n_if #(.WIDTH(8)) if8 ();

    serial_adder_n #(.WIDTH(4)) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (if4.slave)
    );

    serial_adder_n #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (if8.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (observed timeout, required finish)");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] o_busy(input int w);
        return (w == 4) ? 32'(if4.busy) : 32'(if8.busy);
    endfunction
    function automatic logic [31:0] o_done(input int w);
        return (w == 4) ? 32'(if4.done) : 32'(if8.done);
    endfunction
    function automatic logic [31:0] o_sum(input int w);
        return (w == 4) ? 32'(if4.sum) : 32'(if8.sum);
    endfunction
    function automatic logic [31:0] o_cout(input int w);
        return (w == 4) ? 32'(if4.cout) : 32'(if8.cout);
    endfunction
    function automatic logic [31:0] o_ovf(input int w);
        return (w == 4) ? 32'(if4.overflow) : 32'(if8.overflow);
    endfunction

    // Reference: plain integer arithmetic on unsigned and signed views of the operands.
    task automatic model(input int w, input int a, input int b, input int cin, input int sub,
                         output int s, output int c, output int o);
        int m, half, sa, sb, full, r;
        m    = 1 << w;
        half = m / 2;
        sa   = (a >= half) ? a - m : a;
        sb   = (b >= half) ? b - m : b;
        if (sub == 0) begin
            full = a + b + cin;
            s    = full % m;
            c    = (full >= m) ? 1 : 0;
            r    = sa + sb + cin;
        end else begin
            full = a - b - cin;
            s    = (full + m) % m;
            c    = (full >= 0) ? 1 : 0;
            r    = sa - sb - cin;
        end
        o = (r < -half || r > half - 1) ? 1 : 0;
    endtask

    task automatic drive(input int w, input int a, input int b, input int cin, input int sub,
                         input logic start);
        logic [7:0] av, bv;
        av = 8'(a);
        bv = 8'(b);
        if (w == 4) begin
            if4.a = av[3:0]; if4.b = bv[3:0]; if4.cin = cin[0]; if4.sub = sub[0];
            if4.start = start;
        end else begin
            if8.a = av; if8.b = bv; if8.cin = cin[0]; if8.sub = sub[0];
            if8.start = start;
        end
    endtask

    task automatic set_start(input int w, input logic v);
        if (w == 4) if4.start = v;
        else        if8.start = v;
    endtask

    // Called just after the accepting edge; ends just after the edge that enters DONE.
    task automatic finish_op(input int w, input int a, input int b, input int cin,
                             input int sub, input bit disturb, input string tag);
        int es, ec, eo;
        model(w, a, b, cin, sub, es, ec, eo);
        for (int i = 0; i < w; i++) begin
            if (disturb && i == 1) drive(w, ~a, ~b, ~cin & 1, ~sub & 1, 1'b1);
            if (disturb && i == w - 1) set_start(w, 1'b0);
            check($sformatf("%s busy[%0d]", tag, i), o_busy(w), 32'd1);
            check($sformatf("%s nodone[%0d]", tag, i), o_done(w), 32'd0);
            tick();
        end
        check({tag, " done"}, o_done(w), 32'd1);
        check({tag, " busy_off"}, o_busy(w), 32'd0);
        check({tag, " sum"}, o_sum(w), 32'(es));
        check({tag, " cout"}, o_cout(w), 32'(ec));
        check({tag, " ovf"}, o_ovf(w), 32'(eo));
    endtask

    task automatic full_op(input int w, input int a, input int b, input int cin, input int sub,
                           input string tag);
        drive(w, a, b, cin, sub, 1'b1);
        tick();
        set_start(w, 1'b0);
        finish_op(w, a, b, cin, sub, 1'b0, tag);
        tick();
        check({tag, " done_pulse"}, o_done(w), 32'd0);
    endtask

    initial begin
        int w, a, b, cin, sub;
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        drive(4, 0, 0, 0, 0, 1'b0);
        drive(8, 0, 0, 0, 0, 1'b0);
        tick();
        tick();
        for (int k = 0; k < 2; k++) begin
            w = (k == 0) ? 4 : 8;
            check("rst busy", o_busy(w), 32'd0);
            check("rst done", o_done(w), 32'd0);
            check("rst sum", o_sum(w), 32'd0);
            check("rst cout", o_cout(w), 32'd0);
            check("rst ovf", o_ovf(w), 32'd0);
        end
        reset = 1'b0;
        tick();

        full_op(4, 4'b0001, 4'b0001, 0, 0, "p1");
        full_op(4, 4'b1111, 4'b1111, 1, 0, "p2");
        full_op(4, 4'b0111, 4'b0001, 0, 0, "p3");
        full_op(8, 8'h05, 8'h07, 0, 1, "p4");
        full_op(8, 8'h80, 8'h01, 0, 1, "p5");
        check("p5 sum const", o_sum(8), 32'h7F);

        // Start re-pulsed and operands changed mid-RUN, then back-to-back start in DONE.
        drive(4, 4'b0101, 4'b0110, 1, 0, 1'b1);
        tick();
        set_start(4, 1'b0);
        finish_op(4, 4'b0101, 4'b0110, 1, 0, 1'b1, "dist");
        drive(4, 4'b1001, 4'b0011, 0, 1, 1'b1);
        tick();
        set_start(4, 1'b0);
        finish_op(4, 4'b1001, 4'b0011, 0, 1, 1'b0, "b2b");
        tick();
        check("b2b idle", o_done(4), 32'd0);

        // Reset on the second RUN cycle aborts without a done pulse.
        drive(4, 4'b0110, 4'b0111, 0, 0, 1'b1);
        tick();
        set_start(4, 1'b0);
        tick();
        reset = 1'b1;
        tick();
        check("abort busy", o_busy(4), 32'd0);
        check("abort done", o_done(4), 32'd0);
        check("abort sum", o_sum(4), 32'd0);
        check("abort cout", o_cout(4), 32'd0);
        check("abort ovf", o_ovf(4), 32'd0);
        set_start(4, 1'b1);
        tick();
        check("rst_vs_start busy", o_busy(4), 32'd0);
        reset = 1'b0;
        set_start(4, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("abort nodone[%0d]", i), o_done(4), 32'd0);
            check($sformatf("abort idle[%0d]", i), o_busy(4), 32'd0);
        end

        for (int n = 0; n < 24; n++) begin
            w   = (n % 2 == 0) ? 4 : 8;
            a   = int'($urandom_range((1 << w) - 1, 0));
            b   = int'($urandom_range((1 << w) - 1, 0));
            cin = int'($urandom_range(1, 0));
            sub = int'($urandom_range(1, 0));
            full_op(w, a, b, cin, sub, $sformatf("rnd%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/serial_adder_n.md
# serial_adder_n

Parametrised bit-serial adder/subtractor with start/busy/done handshake. It generalises the board's combinational 4-bit ripple adder to WIDTH-bit operands, adds a subtract mode and signed-overflow detection, and computes one bit per clock through a single full-adder cell. It sits between switch/key capture logic and LED/HEX display logic in DE1-SoC designs, and is reusable as a small arithmetic unit in later labs.

## Interface
- WIDTH, default 4, operand and result width in bits; must be at least 2.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  reset, synchronous and active-high.
- start  in  1  request a new operation; sampled only in IDLE or DONE.
- a  in  WIDTH  operand A; captured when start is accepted.
- b  in  WIDTH  operand B; captured when start is accepted.
- cin  in  1  carry-in; captured when start is accepted.
- sub  in  1  mode: 0 = A+B+cin, 1 = A−B−cin; captured when start is accepted.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse marking a new valid result.
- sum  out  WIDTH  result of the last completed operation.
- cout  out  1  carry out. In subtract mode this is the inverted borrow (1 = no borrow).
- overflow  out  1  two's-complement signed overflow of the last completed operation.

## Operation
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1.
  - DONE: done=1, busy=0.
- Accept start:
  - Start is accepted in IDLE or DONE; the next state is RUN.
  - On acceptance, latch opA=a and opB = sub ? ~b : b.
  - Set carry = cin XOR sub, so subtract computes A + ~B + ~cin, i.e. A − B − cin.
  - Clear the bit counter to 0.
- RUN, each cycle:
  - Feed bit 0 of the shift registers to the full-adder cell.
  - Shift opA and opB right by one.
  - Shift the sum bit into the MSB of the internal result shift register.
  - Update carry and increment the counter.
- On the RUN cycle with counter = WIDTH−1:
  - Copy the result shift register (including the final bit) to sum.
  - Set cout = final carry.
  - Set overflow = carry into the MSB XOR final carry.
  - Next state is DONE.
- DONE → IDLE when start=0, or DONE → RUN when start=1 (back-to-back operation).
- start is ignored in RUN. Operand changes in RUN have no effect.
- sum, cout and overflow change only on entry to DONE and hold until the next completion. They never show partial results.
- Reset (at any time, including mid-RUN):
  - State becomes IDLE; the operation is aborted with no done pulse.
  - sum=0, cout=0, overflow=0, busy=0, done=0; counter and shift registers are cleared.
  - reset takes priority over start on the same edge.

## Timing
- Start sampled high at edge k (in IDLE or DONE) → busy is high for exactly WIDTH cycles, after edges k through k+WIDTH−1.
- Result registers update at edge k+WIDTH. done is high for exactly one cycle, after edge k+WIDTH.
- Latency from start to done is WIDTH+1 edges. Peak throughput is one result per WIDTH+1 cycles using back-to-back starts in DONE.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Counter width is $clog2(WIDTH), or 1 when WIDTH=2. Wrap-around of the counter is never reached because RUN exits at WIDTH−1.

## Structure
- Shared package adder_pkg:
  - State enum: IDLE, RUN, DONE.
  - Helper constant function for the counter width.
- Sub-module full_adder_bit: combinational 1-bit full adder (a, b, cin → s, cout). Instantiated once; it is the only arithmetic in the block.
- Top-level wrapper use: a=SW[4:1], b=SW[8:5], cin=SW[0], sub=SW[9], start = a registered KEY press; sum/cout on LEDR. The wrapper is outside this block.

## Test plan
- WIDTH=4, a=0001, b=0001, cin=0, sub=0, start for 1 cycle:
  - busy high 4 cycles, then done pulse; sum=0010, cout=0, overflow=0.
- WIDTH=4, a=1111, b=1111, cin=1, sub=0:
  - sum=1111, cout=1, overflow=0.
- WIDTH=4, a=0111, b=0001, cin=0, sub=0:
  - sum=1000, cout=0, overflow=1.
- WIDTH=8, a=0x05, b=0x07, cin=0, sub=1:
  - sum=0xFE, cout=0 (borrow), overflow=0.
  - Then a=0x80, b=0x01, sub=1 gives sum=0x7F, cout=1, overflow=1.
- WIDTH=4, start pulsed again during RUN, and a/b changed mid-RUN:
  - The first result is unaffected and exactly one done pulse occurs.
  - Start held in the DONE cycle begins a second operation immediately (busy the next cycle).
- WIDTH=4, reset asserted on the 2nd RUN cycle:
  - Next cycle: IDLE, busy=0, sum=0, cout=0, overflow=0, and no done pulse follows.
  - Start with reset high on the same edge is ignored.
